// File: rtl/ws2812_frame_feeder.sv
// Pixel buffer and byte feeder for the WS2812 shifter: serves G,R,B bytes per pixel over request/valid.
// Define WS2812_FEEDER_BRIGHTNESS_EN to scale each fetched byte by (brightness+1)/256.
module ws2812_frame_feeder #(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [7:0]        brightness,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              trigger,
    input  logic              data_request,
    output logic [7:0]        data_out,
    output logic              data_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PRELOAD_WAIT,
        S_ARM,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_LED   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W:0]   NUM_LEDS_W = (ADDR_W + 1)'(NUM_LEDS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] led_idx_q, led_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic              staged_q, staged_d;
    logic              last_q, last_d;
    logic              pending_q, pending_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;
    logic [7:0]        data_out_q, data_out_d;

    logic [23:0]       pix_mem [NUM_LEDS];
    logic [23:0]       rd_q;
    logic [7:0]        sel_byte;
    logic [7:0]        scaled_byte;
    logic              is_last_byte;

    // Buffer is not reset; the read port samples the current pixel every cycle and
    // the FSM only uses it in PRELOAD_WAIT, so late writes to unfetched pixels show up.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < NUM_LEDS_W)) begin
            pix_mem[wr_addr] <= wr_data;
        end
        rd_q <= pix_mem[led_idx_q];
    end

    always_comb begin
        case (byte_idx_q)
            2'd0:    sel_byte = rd_q[15:8];
            2'd1:    sel_byte = rd_q[23:16];
            default: sel_byte = rd_q[7:0];
        endcase
    end

`ifdef WS2812_FEEDER_BRIGHTNESS_EN
    logic [15:0] product;
    assign product     = {8'd0, sel_byte} * ({8'd0, brightness} + 16'd1);
    assign scaled_byte = 8'(product >> 8);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign scaled_byte       = sel_byte;
`endif

    assign is_last_byte = (led_idx_q == LAST_LED) && (byte_idx_q == 2'd2);

    always_comb begin
        state_d    = state_q;
        led_idx_d  = led_idx_q;
        byte_idx_d = byte_idx_q;
        staged_d   = staged_q;
        last_d     = last_q;
        pending_d  = pending_q;
        busy_d     = busy_q;
        underrun_d = underrun_q;
        data_out_d = data_out_q;

        if (start && busy_q) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start || pending_q) begin
                    led_idx_d  = '0;
                    byte_idx_d = 2'd0;
                    staged_d   = 1'b0;
                    last_d     = 1'b0;
                    pending_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_PRELOAD_WAIT;
            end
            S_PRELOAD_WAIT: begin
                data_out_d = scaled_byte;
                staged_d   = 1'b1;
                // The very first byte of a frame goes through ARM to kick the shifter.
                state_d    = ((led_idx_q == '0) && (byte_idx_q == 2'd0)) ? S_ARM : S_STREAM;
            end
            S_ARM, S_STREAM: begin
                if (data_request) begin
                    if (staged_q) begin
                        staged_d = 1'b0;
                        if (is_last_byte) begin
                            last_d  = 1'b1;
                            state_d = S_STREAM;
                        end else begin
                            if (byte_idx_q == 2'd2) begin
                                byte_idx_d = 2'd0;
                                led_idx_d  = led_idx_q + ADDR_W'(1);
                            end else begin
                                byte_idx_d = byte_idx_q + 2'd1;
                            end
                            state_d = S_FETCH;
                        end
                    end else begin
                        if (!last_q) begin
                            underrun_d = 1'b1;
                        end
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            led_idx_q  <= '0;
            byte_idx_q <= 2'd0;
            staged_q   <= 1'b0;
            last_q     <= 1'b0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            data_out_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            led_idx_q  <= led_idx_d;
            byte_idx_q <= byte_idx_d;
            staged_q   <= staged_d;
            last_q     <= last_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            data_out_q <= data_out_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = (state_q == S_DONE);
    assign trigger    = (state_q == S_ARM);
    assign data_valid = staged_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_ws2812_frame_feeder.sv
// Directed bench for ws2812_frame_feeder with a simple shifter model requesting a byte every 20 cycles.
module tb_ws2812_frame_feeder;

    localparam int ACT_NONE  = 0;
    localparam int ACT_START = 1;
    localparam int ACT_WRITE = 2;
    localparam int ACT_RESET = 3;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  brightness;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        trigger;
    logic        data_request;
    logic [7:0]  data_out;
    logic        data_valid;

    int          tests;
    int          fails;
    logic [7:0]  exp_bytes [0:8];

    ws2812_frame_feeder #(.NUM_LEDS(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .brightness   (brightness),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done),
        .trigger      (trigger),
        .data_request (data_request),
        .data_out     (data_out),
        .data_valid   (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic write_pix(input logic [1:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Wire order is G, R, B for each pixel.
    task automatic load_frame(input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] p2);
        exp_bytes[0] = p0[15:8]; exp_bytes[1] = p0[23:16]; exp_bytes[2] = p0[7:0];
        exp_bytes[3] = p1[15:8]; exp_bytes[4] = p1[23:16]; exp_bytes[5] = p1[7:0];
        exp_bytes[6] = p2[15:8]; exp_bytes[7] = p2[23:16]; exp_bytes[8] = p2[7:0];
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_frame(input int n, input int first_delay, input int act, input int act_at,
                             output bit aborted);
        int         idx;
        bit         hold_ok;
        bit         seen;
        logic       v;
        logic [7:0] d;
        aborted = 1'b0;
        idx     = 0;
        hold_ok = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (trigger === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("trigger_seen", seen, 1);
        if (!seen) return;
        for (int i = 0; i < first_delay; i++) begin
            if (!(trigger === 1'b1 && data_valid === 1'b1 && data_out === exp_bytes[0])) hold_ok = 1'b0;
            tick();
        end
        check("trigger_hold", hold_ok, 1);
        for (int r = 0; r < n + 2; r++) begin
            data_request = 1'b1;
            v = data_valid;
            d = data_out;
            tick();
            data_request = 1'b0;
            if (v !== 1'b1) break;
            if (idx < n) check($sformatf("byte%0d", idx), d, exp_bytes[idx]);
            idx++;
            for (int g = 0; g < 19; g++) begin
                if (idx == act_at) begin
                    if (act == ACT_START) begin
                        start = (g == 2 || g == 5 || g == 8);
                    end else if (act == ACT_WRITE) begin
                        wr_en   = (g == 2 || g == 3);
                        wr_addr = (g == 2) ? 2'd2 : 2'd3;
                        wr_data = (g == 2) ? 24'hABCDEF : 24'h5A5A5A;
                    end else if (act == ACT_RESET && g == 5) begin
                        check("pre_reset_valid", data_valid, 1);
                        rst_n = 1'b0;
                        #1;
                        check("rst_busy", busy, 0);
                        check("rst_frame_done", frame_done, 0);
                        check("rst_trigger", trigger, 0);
                        check("rst_data_valid", data_valid, 0);
                        check("rst_data_out", data_out, 0);
                        aborted = 1'b1;
                        return;
                    end
                end
                tick();
            end
            start = 1'b0;
            wr_en = 1'b0;
        end
        check("byte_count", idx, n);
        check("frame_done_pulse", frame_done, 1);
        check("busy_in_done", busy, 1);
        tick();
        check("frame_done_clear", frame_done, 0);
        check("busy_fall", busy, 0);
    endtask

    initial begin
        bit aborted;
        bit idle_ok;
        tests        = 0;
        fails        = 0;
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = 2'd0;
        wr_data      = 24'd0;
        brightness   = 8'hFF;
        start        = 1'b0;
        data_request = 1'b0;

        repeat (2) tick();
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_trigger", trigger, 0);
        check("reset_data_valid", data_valid, 0);
        check("reset_data_out", data_out, 0);
        rst_n = 1'b1;
        tick();

        // Basic frame; three extra starts mid-frame queue exactly one follow-on frame.
        write_pix(2'd0, 24'h112233);
        write_pix(2'd1, 24'h445566);
        write_pix(2'd2, 24'h778899);
        load_frame(24'h112233, 24'h445566, 24'h778899);
        pulse_start();
        run_frame(9, 20, ACT_START, 2, aborted);
        tick();
        check("pending_restart", busy, 1);

        // Follow-on frame: pixel 2 rewritten while byte 1 is up, out-of-range write ignored.
        load_frame(24'h112233, 24'h445566, 24'hABCDEF);
        run_frame(9, 20, ACT_WRITE, 1, aborted);
        idle_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (busy !== 1'b0 || trigger !== 1'b0) idle_ok = 1'b0;
            tick();
        end
        check("extra_start_dropped", idle_ok, 1);

        // Reset in the middle of byte 4, then replay with a long first-request delay.
        pulse_start();
        run_frame(9, 20, ACT_RESET, 4, aborted);
        check("reset_aborted", aborted, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        run_frame(9, 1000, ACT_NONE, 0, aborted);

        // Brightness scaling.
        brightness = 8'h7F;
        write_pix(2'd0, 24'hFF80FF);
        write_pix(2'd1, 24'hFFFFFF);
        write_pix(2'd2, 24'h000000);
`ifdef WS2812_FEEDER_BRIGHTNESS_EN
        exp_bytes[0] = 8'h40; exp_bytes[1] = 8'h7F; exp_bytes[2] = 8'h7F;
        exp_bytes[3] = 8'h7F; exp_bytes[4] = 8'h7F; exp_bytes[5] = 8'h7F;
`else
        exp_bytes[0] = 8'h80; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'hFF;
        exp_bytes[3] = 8'hFF; exp_bytes[4] = 8'hFF; exp_bytes[5] = 8'hFF;
`endif
        exp_bytes[6] = 8'h00; exp_bytes[7] = 8'h00; exp_bytes[8] = 8'h00;
        pulse_start();
        run_frame(9, 20, ACT_NONE, 0, aborted);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
